// File: rtl/conversor_pkg.sv
// conversor_pkg: FSM states, segment constants and the double-dabble digit adjust shared by the BCD converter.
package conversor_pkg;

    typedef enum logic [1:0] {OCIOSO, CARREGA, DESLOCA, FIM} estado_t;

    // Active-low a..g, bit6 = a, bit0 = g
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h7E;
    localparam logic [6:0] SEG_ZERO  = 7'h01;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/conversor_bcd7b_decodificador7seg.sv
// decodificador7seg: combinational BCD digit to active-low 7-segment pattern; codes 10-15 decode blank.
module decodificador7seg
    import conversor_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0: o_seg = 7'h01;
            4'd1: o_seg = 7'h4F;
            4'd2: o_seg = 7'h12;
            4'd3: o_seg = 7'h06;
            4'd4: o_seg = 7'h4C;
            4'd5: o_seg = 7'h24;
            4'd6: o_seg = 7'h20;
            4'd7: o_seg = 7'h0F;
            4'd8: o_seg = 7'h00;
            4'd9: o_seg = 7'h04;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/conversor_bcd7b.sv
// conversor_bcd7b: sequential 7-bit to 3-digit BCD converter (double dabble) with blanked 7-segment outputs.
// Define COMPLEMENTO2_EN to interpret valor as two's complement and drive the minus sign.
module conversor_bcd7b
    import conversor_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inicio,
    input  logic [0:6] valor,
    output logic       ocupado,
    output logic       pronto,
    output logic       negativo,
    output logic [3:0] dig_c,
    output logic [3:0] dig_d,
    output logic [3:0] dig_u,
    output logic [6:0] seg_sinal,
    output logic [6:0] seg_c,
    output logic [6:0] seg_d,
    output logic [6:0] seg_u
);

    estado_t     r_estado;
    logic [6:0]  r_valor;
    logic [6:0]  r_mag;
    logic        r_neg;
    logic [11:0] r_bcd;
    logic [2:0]  r_cnt;
    logic [11:0] w_adj;
    logic [6:0]  w_seg_c;
    logic [6:0]  w_seg_d;
    logic [6:0]  w_seg_u;

    assign w_adj = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};

    decodificador7seg u_dec_c (.i_bcd(r_bcd[11:8]), .o_seg(w_seg_c));
    decodificador7seg u_dec_d (.i_bcd(r_bcd[7:4]),  .o_seg(w_seg_d));
    decodificador7seg u_dec_u (.i_bcd(r_bcd[3:0]),  .o_seg(w_seg_u));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado  <= OCIOSO;
            r_valor   <= '0;
            r_mag     <= '0;
            r_neg     <= 1'b0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            ocupado   <= 1'b0;
            pronto    <= 1'b0;
            negativo  <= 1'b0;
            dig_c     <= '0;
            dig_d     <= '0;
            dig_u     <= '0;
            seg_sinal <= SEG_BLANK;
            seg_c     <= SEG_BLANK;
            seg_d     <= SEG_BLANK;
            seg_u     <= SEG_ZERO;
        end else begin
            pronto <= 1'b0;
            case (r_estado)
                OCIOSO: if (inicio) begin
                    r_valor  <= valor;
                    ocupado  <= 1'b1;
                    r_estado <= CARREGA;
                end
                CARREGA: begin
`ifdef COMPLEMENTO2_EN
                    r_neg <= r_valor[6];
                    r_mag <= r_valor[6] ? ~r_valor + 7'd1 : r_valor;
`else
                    r_neg <= 1'b0;
                    r_mag <= r_valor;
`endif
                    r_bcd    <= '0;
                    r_cnt    <= '0;
                    r_estado <= DESLOCA;
                end
                DESLOCA: begin
                    r_bcd <= 12'({w_adj, r_mag[6]});
                    r_mag <= {r_mag[5:0], 1'b0};
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd6) r_estado <= FIM;
                end
                FIM: begin
                    dig_c     <= r_bcd[11:8];
                    dig_d     <= r_bcd[7:4];
                    dig_u     <= r_bcd[3:0];
                    negativo  <= r_neg;
                    seg_sinal <= r_neg ? SEG_MINUS : SEG_BLANK;
                    // Leading-zero blanking: tens only go dark when hundreds are also zero
                    seg_c     <= (r_bcd[11:8] == 4'd0) ? SEG_BLANK : w_seg_c;
                    seg_d     <= (r_bcd[11:4] == 8'd0) ? SEG_BLANK : w_seg_d;
                    seg_u     <= w_seg_u;
                    pronto    <= 1'b1;
                    ocupado   <= 1'b0;
                    r_estado  <= OCIOSO;
                end
                default: r_estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_conversor_bcd7b.sv
// tb_conversor_bcd7b: directed checks of conversor_bcd7b; expected values follow COMPLEMENTO2_EN when defined.
module tb_conversor_bcd7b;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inicio = 1'b0;
    logic [0:6] valor = '0;
    logic       ocupado, pronto, negativo;
    logic [3:0] dig_c, dig_d, dig_u;
    logic [6:0] seg_sinal, seg_c, seg_d, seg_u;
    int         passed = 0;
    int         total = 0;

    conversor_bcd7b dut (
        .clk(clk), .rst(rst), .inicio(inicio), .valor(valor),
        .ocupado(ocupado), .pronto(pronto), .negativo(negativo),
        .dig_c(dig_c), .dig_d(dig_d), .dig_u(dig_u),
        .seg_sinal(seg_sinal), .seg_c(seg_c), .seg_d(seg_d), .seg_u(seg_u)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pronto(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!pronto && n < 20);
    endtask

    task automatic convert(input logic [6:0] v, input string tag);
        int n;
        valor  = v;
        inicio = 1'b1;
        tick();
        inicio = 1'b0;
        check({tag, "_ocupado"}, ocupado, 1);
        wait_pronto(n);
        check({tag, "_latency"}, n, 9);
    endtask

    task automatic check_out(input string tag, input logic neg, input logic [3:0] c, d, u,
                             input logic [6:0] ss, sc, sd, su);
        check({tag, "_neg"}, negativo, neg);
        check({tag, "_dig_c"}, dig_c, c);
        check({tag, "_dig_d"}, dig_d, d);
        check({tag, "_dig_u"}, dig_u, u);
        check({tag, "_seg_sinal"}, seg_sinal, ss);
        check({tag, "_seg_c"}, seg_c, sc);
        check({tag, "_seg_d"}, seg_d, sd);
        check({tag, "_seg_u"}, seg_u, su);
    endtask

    initial begin
        int n;
        int seen;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ocupado", ocupado, 0);
        check("rst_pronto", pronto, 0);
        check_out("rst", 0, 0, 0, 0, 7'h7F, 7'h7F, 7'h7F, 7'h01);

        convert(7'b0010111, "v23");
        check_out("v23", 0, 0, 2, 3, 7'h7F, 7'h7F, 7'h12, 7'h06);
        tick();
        check("v23_pronto_drop", pronto, 0);
        check("v23_ocupado_drop", ocupado, 0);
        check("v23_hold_dig_u", dig_u, 3);

        convert(7'b1000000, "v64");
`ifdef COMPLEMENTO2_EN
        check_out("v64", 1, 0, 6, 4, 7'h7E, 7'h7F, 7'h20, 7'h4C);
`else
        check_out("v64", 0, 0, 6, 4, 7'h7F, 7'h7F, 7'h20, 7'h4C);
`endif

        convert(7'b1111111, "v127");
`ifdef COMPLEMENTO2_EN
        check_out("v127", 1, 0, 0, 1, 7'h7E, 7'h7F, 7'h7F, 7'h4F);
`else
        check_out("v127", 0, 1, 2, 7, 7'h7F, 7'h4F, 7'h12, 7'h0F);
`endif

        convert(7'b1100100, "v100");
`ifdef COMPLEMENTO2_EN
        check_out("v100", 1, 0, 2, 8, 7'h7E, 7'h7F, 7'h12, 7'h00);
`else
        check_out("v100", 0, 1, 0, 0, 7'h7F, 7'h4F, 7'h01, 7'h01);
`endif

        convert(7'd5, "v5");
        check_out("v5", 0, 0, 0, 5, 7'h7F, 7'h7F, 7'h7F, 7'h24);

        // inicio held high, valor changes mid-conversion
        valor  = 7'd23;
        inicio = 1'b1;
        tick();
        n = 0;
        repeat (3) begin
            tick();
            n++;
        end
        valor = 7'b1111111;
        while (!pronto && n < 20) begin
            tick();
            n++;
        end
        check("hold_latency", n, 9);
        check_out("hold", 0, 0, 2, 3, 7'h7F, 7'h7F, 7'h12, 7'h06);
        tick();
        check("hold_restart_ocupado", ocupado, 1);
        check("hold_restart_pronto", pronto, 0);
        inicio = 1'b0;
        wait_pronto(n);
        check("hold2_latency", n, 9);
`ifdef COMPLEMENTO2_EN
        check_out("hold2", 1, 0, 0, 1, 7'h7E, 7'h7F, 7'h7F, 7'h4F);
`else
        check_out("hold2", 0, 1, 2, 7, 7'h7F, 7'h4F, 7'h12, 7'h0F);
`endif

        // reset in the middle of DESLOCA
        valor  = 7'd45;
        inicio = 1'b1;
        tick();
        inicio = 1'b0;
        repeat (4) tick();
        check("abort_busy", ocupado, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ocupado", ocupado, 0);
        check("abort_pronto", pronto, 0);
        check_out("abort", 0, 0, 0, 0, 7'h7F, 7'h7F, 7'h7F, 7'h01);
        seen = 0;
        repeat (12) begin
            tick();
            if (pronto) seen++;
        end
        check("abort_no_pronto", seen, 0);
        check("abort_idle", ocupado, 0);
        convert(7'd45, "v45");
        check_out("v45", 0, 0, 4, 5, 7'h7F, 7'h7F, 7'h4C, 7'h24);

        // rst wins over inicio in the same cycle
        rst    = 1'b1;
        inicio = 1'b1;
        valor  = 7'd9;
        tick();
        rst    = 1'b0;
        inicio = 1'b0;
        check("prio_ocupado", ocupado, 0);
        tick();
        check("prio_ocupado_after", ocupado, 0);
        check("prio_dig_u", dig_u, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/conversor_bcd7b.md
CONVERSOR_BCD7B -- requirements
Module: conversor_bcd7b

Interface
REQ-001 SHALL have one clock and a reset that is synchronous and active-high: clk, rst.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock shared with acumulador7b.
REQ-003 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port inicio, input, 1 bit: conversion request, sampled each rising edge.
REQ-005 SHALL have port valor, input, [0:6]: accumulator Q; valor[0] is MSB.
REQ-006 SHALL have port ocupado, output, 1 bit: high while a conversion is in progress.
REQ-007 SHALL have port pronto, output, 1 bit: one-cycle completion pulse.
REQ-008 SHALL have port negativo, output, 1 bit: sign of the last converted value.
REQ-009 SHALL have ports dig_c, dig_d and dig_u, each output, 4 bits: BCD hundreds, tens and units.
REQ-010 SHALL have ports seg_sinal, seg_c, seg_d and seg_u, each output, [6:0]: a..g segments (bit6=a, bit0=g), active-low.

Function
REQ-011 SHALL implement FSM states OCIOSO, CARREGA, DESLOCA and FIM.
REQ-012 SHALL, in OCIOSO with inicio=1 at an edge, capture valor and enter CARREGA; inicio=0 SHALL stay in OCIOSO.
REQ-013 SHALL, in CARREGA, compute the 7-bit magnitude and sign, clear the BCD scratch and the 3-bit shift counter, and go to DESLOCA.
REQ-014 SHALL, in DESLOCA, per cycle: add 3 to each scratch BCD digit >=5, then shift magnitude MSB into the scratch; after exactly 7 shifts go to FIM.
REQ-015 SHALL, in FIM, load dig_c/dig_d/dig_u/negativo and all segment outputs from the scratch, assert pronto, and return to OCIOSO.
REQ-016 SHALL assert pronto for exactly one cycle, 9 rising edges after the edge that sampled inicio (1 CARREGA + 7 DESLOCA + 1 FIM).
REQ-017 SHALL drive ocupado=1 in CARREGA, DESLOCA and FIM, and 0 in OCIOSO.
REQ-018 SHALL ignore inicio while ocupado=1; back-to-back conversions SHALL start no earlier than the edge after pronto.
REQ-019 SHALL hold all digit, sign and segment outputs stable between FIM updates; valor changes mid-conversion SHALL have no effect.
REQ-020 SHALL blank leading zeros: seg_c all 1s when dig_c=0; seg_d all 1s when dig_c=0 and dig_d=0; seg_u always lit.
REQ-021 SHALL drive seg_sinal with only g lit when negativo=1, and all 1s otherwise.
REQ-022 SHALL decode BCD 0-9 to standard 7-segment patterns; codes 10-15 are unreachable, and their decode SHALL be blank.

Reset
REQ-023 SHALL, on rst=1 at an edge, enter OCIOSO from any state, aborting any conversion without a pronto pulse.
REQ-024 SHALL reset outputs to: ocupado=0, pronto=0, negativo=0, dig_*=0, seg_sinal/seg_c/seg_d blank, seg_u showing "0".
REQ-025 SHALL give rst priority over inicio in the same cycle.

Configuration
REQ-026 SHALL, with COMPLEMENTO2_EN defined, treat valor as two's complement: negativo=valor[0]; magnitude = two's-complement negation when negative (-64 -> 64); dig_c is always 0.
REQ-027 SHALL, with COMPLEMENTO2_EN undefined, treat valor as unsigned 0..127: negativo fixed 0, seg_sinal always blank, dig_c 0 or 1.

Structure
REQ-028 SHALL place FSM state encodings, the blank segment constant and the minus segment constant in a shared include/package conversor_pkg.
REQ-029 SHALL use sub-module decodificador7seg (4-bit BCD in, 7-bit active-low out, combinational), instantiated three times.
REQ-030 SHALL register its outputs; no combinational path from valor or inicio to any output.

Verification
REQ-031 SHALL cover reset: rst=1 for 2 cycles -> ocupado=0, pronto=0, seg_u shows "0", others blank.
REQ-032 SHALL cover: valor=7'b0010111 (23), inicio pulse -> pronto exactly 9 edges later, dig_d=2, dig_u=3, seg_c blank, negativo=0.
REQ-033 SHALL cover: COMPLEMENTO2_EN defined, valor=7'b1000000 -> negativo=1, dig_d=6, dig_u=4, seg_sinal shows minus; undefined -> dig_c=0, dig_d=6, dig_u=4, negativo=0.
REQ-034 SHALL cover: COMPLEMENTO2_EN undefined, valor=7'b1111111 -> dig_c=1, dig_d=2, dig_u=7.
REQ-035 SHALL cover: inicio held high across a conversion, with valor changed at cycle 3 -> result reflects the value captured at start, and the next conversion begins the edge after pronto.
REQ-036 SHALL cover: rst asserted during DESLOCA -> no pronto, outputs at reset values, and a new inicio converts correctly.
